fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end that consumes the next-PC selection and flush produced by the PC-select mux. It owns the PC register, drives the instruction-memory request/valid handshake, and loads the IF/ID pipeline register. It squashes in-flight and buffered fetches on redirect, and holds or buffers instructions under decode stall. It returns PC+4 to the PC-select mux.

Parameters:
- Width, 32, PC/address width.
- IWidth, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- PC_next  in  Width  next PC from PC-select mux.
- redirect  in  1  flush/redirect from PC-select mux (jump or taken branch); PC_next is the target.
- stall  in  1  decode stall from hazard unit.
- PC_added  out  Width  pc_q + 4, fed back to the PC-select mux.
- imem_req  out  1  fetch request.
- imem_addr  out  Width  fetch address (= pc_q).
- imem_valid  in  1  response strobe, one cycle per accepted request.
- imem_rdata  in  IWidth  instruction data, valid with imem_valid.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_pc  out  Width  PC of the IF/ID instruction.
- ifid_instr  out  IWidth  instruction; NOP (32'h0000_0013) when ifid_valid=0.

Behaviour:
- Reset (async):
  - pc_q=RESET_PC, state=REQ.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP.
  - Buffer empty; pend_pc=0.
- Handshake:
  - imem_req=1 in REQ and DROP, 0 in HOLD.
  - imem_addr is stable while imem_req=1 until imem_valid.
  - At most one outstanding request. Zero-wait memory (valid in the same cycle as req) is legal.
  - PC_added = pc_q + 4, modulo 2^Width (wraps silently).
- States: REQ, DROP, HOLD.
- REQ (request for pc_q in flight):
  - valid & !redirect & !stall: IF/ID <= {1, pc_q, rdata}; pc_q <= PC_next; stay REQ.
  - valid & !redirect & stall: buffer rdata and pc_q; -> HOLD. IF/ID unchanged.
  - valid & redirect: discard rdata; pc_q <= PC_next; ifid_valid <= 0; stay REQ.
  - !valid & redirect: pend_pc <= PC_next; ifid_valid <= 0; -> DROP.
  - !valid & !redirect: IF/ID holds if stall, else ifid_valid <= 0 (bubble).
- DROP (squashed request still in flight):
  - imem_addr stays at the old pc_q.
  - Further redirects overwrite pend_pc.
  - On imem_valid: discard data; pc_q <= pend_pc (or PC_next if redirect this cycle); -> REQ.
  - ifid_valid <= 0 unless stall=1, in which case IF/ID holds.
- HOLD (one instruction buffered):
  - stall=1 & !redirect: hold everything.
  - stall=0 & !redirect: IF/ID <= buffer; pc_q <= PC_next; -> REQ.
  - redirect (any stall): drop buffer; ifid_valid <= 0; pc_q <= PC_next; -> REQ.
- Priority: redirect > stall > normal advance. A flush always clears ifid_valid, even under stall.
- Reset mid-operation: the outstanding request is abandoned. The memory must not return imem_valid after reset deasserts for a pre-reset request; this is the system's responsibility.
- Latency: zero-wait memory gives one instruction per cycle. Redirect costs one bubble with a zero-wait response, more if the response is late (DROP).

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched (32) and perf_squashed (32), both reset to 0 and saturating at all-ones.
  - perf_fetched increments on each IF/ID load with valid=1.
  - perf_squashed increments on each discarded imem_valid response or dropped HOLD buffer.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {REQ, DROP, HOLD}.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC constant.
- Sub-module ifid_reg: the IF/ID register with load, hold and flush controls and NOP insertion. fetch_unit holds the PC, FSM, buffer and handshake.

Test Plan:
- Reset: assert reset mid-cycle with RESET_PC=0 -> outputs clear immediately. After release: imem_req=1, imem_addr=0, PC_added=4, ifid_valid=0, ifid_instr=NOP.
- Streaming: zero-wait memory, PC_next=PC_added -> IF/ID shows pc 0,4,8,C on consecutive cycles with matching rdata, ifid_valid continuously 1.
- Redirect with zero-wait response: redirect=1 with PC_next=0x100 while fetching 0x8 -> 0x8 data discarded, one bubble (ifid_valid=0), next fetch at 0x100.
- Redirect with late response: memory delays 3 cycles, redirect to 0x200 in cycle 1 -> imem_addr stays 0x8 until valid, data dropped, then imem_addr=0x200. No IF/ID load of 0x8.
- Stall and buffer: stall=1 for 3 cycles while valid returns for 0x10 -> imem_req=0 in HOLD, IF/ID unchanged. On stall=0, IF/ID loads 0x10 and fetch resumes at 0x14.
- Flush beats stall: HOLD with stall=1, redirect to 0x40 -> ifid_valid=0 next cycle, buffer dropped, imem_addr=0x40. With FETCH_PERF_EN, perf_squashed increments by 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
//
// Contents:
//   fetch_state_t    : fetch FSM states (REQ, DROP, HOLD)
//   NOP_INSTR        : instruction placed in IF/ID when it holds no live instruction
//   DEFAULT_RESET_PC : default PC loaded at reset
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and flush
//
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   load               : capture pc_in/instr_in as a live instruction
//   flush              : invalidate the register (wins over load)
//   pc_in, instr_in    : instruction being loaded
//   valid, pc, instr   : register contents; instr is NOP whenever valid=0
// Neither load nor flush asserted means hold.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int Width  = 32,
  parameter int IWidth = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [Width-1:0]  pc_in,
  input  logic [IWidth-1:0] instr_in,
  output logic              valid,
  output logic [Width-1:0]  pc,
  output logic [IWidth-1:0] instr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= IWidth'(NOP_INSTR);
    end else if (flush) begin
      // pc is left as-is; only valid/instr carry meaning for a bubble
      valid <= 1'b0;
      instr <= IWidth'(NOP_INSTR);
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC register, imem handshake, IF/ID load
//
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   PC_next, redirect                : next PC and flush from the PC-select mux
//   stall                            : decode stall from the hazard unit
//   PC_added                         : pc_q + 4 (wrapping), back to the PC-select mux
//   imem_req, imem_addr              : fetch request and address (= pc_q)
//   imem_valid, imem_rdata           : one-cycle response strobe and data
//   ifid_valid, ifid_pc, ifid_instr  : IF/ID register contents
//   perf_fetched, perf_squashed      : saturating event counters (FETCH_PERF_EN only)
// Optional build macro: FETCH_PERF_EN adds the two performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               Width    = 32,
  parameter int               IWidth   = 32,
  parameter logic [Width-1:0] RESET_PC = Width'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [Width-1:0]  PC_next,
  input  logic              redirect,
  input  logic              stall,
  output logic [Width-1:0]  PC_added,
  output logic              imem_req,
  output logic [Width-1:0]  imem_addr,
  input  logic              imem_valid,
  input  logic [IWidth-1:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed,
`endif
  output logic              ifid_valid,
  output logic [Width-1:0]  ifid_pc,
  output logic [IWidth-1:0] ifid_instr
);

  fetch_state_t      state_q, state_d;
  logic [Width-1:0]  pc_q, pc_d;
  logic [Width-1:0]  pend_q, pend_d;
  logic [Width-1:0]  buf_pc_q;
  logic [IWidth-1:0] buf_instr_q;
  logic              buf_load;
  logic              ifid_load, ifid_flush;
  logic [Width-1:0]  ld_pc;
  logic [IWidth-1:0] ld_instr;
  logic              squash;

  assign imem_req  = (state_q != HOLD);
  assign imem_addr = pc_q;
  assign PC_added  = pc_q + Width'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= IWidth'(NOP_INSTR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (buf_load) begin
        buf_pc_q    <= pc_q;
        buf_instr_q <= imem_rdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    buf_load   = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ld_pc      = pc_q;
    ld_instr   = imem_rdata;
    squash     = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_valid) begin
          if (redirect) begin
            pc_d       = PC_next;
            ifid_flush = 1'b1;
            squash     = 1'b1;
          end else if (stall) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = PC_next;
          end
        end else if (redirect) begin
          // pc_q must stay on the address in flight until its response returns
          pend_d     = PC_next;
          ifid_flush = 1'b1;
          state_d    = DROP;
        end else begin
          ifid_flush = !stall;
        end
      end
      DROP: begin
        if (redirect) pend_d = PC_next;
        ifid_flush = redirect || !stall;
        if (imem_valid) begin
          squash  = 1'b1;
          pc_d    = redirect ? PC_next : pend_q;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          squash     = 1'b1;
          pc_d       = PC_next;
          state_d    = REQ;
        end else if (!stall) begin
          ifid_load = 1'b1;
          ld_pc     = buf_pc_q;
          ld_instr  = buf_instr_q;
          pc_d      = PC_next;
          state_d   = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  ifid_reg #(
    .Width (Width),
    .IWidth(IWidth)
  ) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .pc_in   (ld_pc),
    .instr_in(ld_instr),
    .valid   (ifid_valid),
    .pc      (ifid_pc),
    .instr   (ifid_instr)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (ifid_load && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (squash && perf_squashed != '1) perf_squashed <= perf_squashed + 32'd1;
    end
  end
`else
  // squash only feeds the counters; keep it referenced in the default build
  logic unused_squash;
  assign unused_squash = squash;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] PC_next;
  logic        redirect;
  logic        stall;
  logic [31:0] PC_added;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int n_tests;
  int n_fail;

  localparam logic [31:0] N = 32'h0000_0013;

  fetch_unit #(
    .Width(32), .IWidth(32), .RESET_PC(32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PC_next   (PC_next),
    .redirect  (redirect),
    .stall     (stall),
    .PC_added  (PC_added),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
`ifdef FETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed),
`endif
    .ifid_valid(ifid_valid),
    .ifid_pc   (ifid_pc),
    .ifid_instr(ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic        stall;
    logic        valid;
    logic [31:0] pcn;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic s, input logic val,
                              input logic [31:0] pcn, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins);
    vec_t t;
    t.redirect = r;   t.stall = s;     t.valid = val;
    t.pcn = pcn;      t.rdata = rd;
    t.exp_req = req;  t.exp_addr = addr;
    t.exp_v = v;      t.exp_pc = pc;   t.exp_instr = ins;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // redirect, stall, valid, PC_next, rdata | req, addr (pre-edge) | ifid v, pc, instr (post-edge)
    // streaming 0,4,8,C
    vecs[0]  = mk(0,0,1,32'h004,32'hAA00_0000, 1,32'h000, 1,32'h000,32'hAA00_0000);
    vecs[1]  = mk(0,0,1,32'h008,32'hAA00_0004, 1,32'h004, 1,32'h004,32'hAA00_0004);
    vecs[2]  = mk(0,0,1,32'h00C,32'hAA00_0008, 1,32'h008, 1,32'h008,32'hAA00_0008);
    vecs[3]  = mk(0,0,1,32'h010,32'hAA00_000C, 1,32'h00C, 1,32'h00C,32'hAA00_000C);
    // redirect with zero-wait response: one bubble
    vecs[4]  = mk(1,0,1,32'h100,32'hAA00_0010, 1,32'h010, 0,32'h000,N);
    vecs[5]  = mk(0,0,1,32'h104,32'hAA00_0100, 1,32'h100, 1,32'h100,32'hAA00_0100);
    // redirect with late response (DROP)
    vecs[6]  = mk(1,0,0,32'h200,32'h0,         1,32'h104, 0,32'h000,N);
    vecs[7]  = mk(0,0,0,32'h000,32'h0,         1,32'h104, 0,32'h000,N);
    vecs[8]  = mk(0,0,0,32'h000,32'h0,         1,32'h104, 0,32'h000,N);
    vecs[9]  = mk(0,0,1,32'h000,32'hAA00_0104, 1,32'h104, 0,32'h000,N);
    vecs[10] = mk(0,0,1,32'h204,32'hAA00_0200, 1,32'h200, 1,32'h200,32'hAA00_0200);
    // stall with buffered response (HOLD)
    vecs[11] = mk(0,1,1,32'h208,32'hAA00_0204, 1,32'h204, 1,32'h200,32'hAA00_0200);
    vecs[12] = mk(0,1,0,32'h208,32'h0,         0,32'h204, 1,32'h200,32'hAA00_0200);
    vecs[13] = mk(0,1,0,32'h208,32'h0,         0,32'h204, 1,32'h200,32'hAA00_0200);
    vecs[14] = mk(0,0,0,32'h208,32'h0,         0,32'h204, 1,32'h204,32'hAA00_0204);
    vecs[15] = mk(0,0,1,32'h20C,32'hAA00_0208, 1,32'h208, 1,32'h208,32'hAA00_0208);
    // flush beats stall in HOLD
    vecs[16] = mk(0,1,1,32'h210,32'hAA00_020C, 1,32'h20C, 1,32'h208,32'hAA00_0208);
    vecs[17] = mk(1,1,0,32'h040,32'h0,         0,32'h20C, 0,32'h000,N);
    vecs[18] = mk(0,0,1,32'h044,32'hAA00_0040, 1,32'h040, 1,32'h040,32'hAA00_0040);
    // late response without redirect: bubble, then bubble held under stall
    vecs[19] = mk(0,0,0,32'h044,32'h0,         1,32'h044, 0,32'h000,N);
    vecs[20] = mk(0,1,0,32'h044,32'h0,         1,32'h044, 0,32'h000,N);
    vecs[21] = mk(0,0,1,32'h048,32'hAA00_0044, 1,32'h044, 1,32'h044,32'hAA00_0044);
    // second redirect in DROP overwrites the pending target
    vecs[22] = mk(1,0,0,32'h300,32'h0,         1,32'h048, 0,32'h000,N);
    vecs[23] = mk(1,1,0,32'h400,32'h0,         1,32'h048, 0,32'h000,N);
    vecs[24] = mk(0,0,1,32'h000,32'hAA00_0048, 1,32'h048, 0,32'h000,N);
    vecs[25] = mk(0,0,1,32'h404,32'hAA00_0400, 1,32'h400, 1,32'h400,32'hAA00_0400);
    // PC_added wrap at the top of the address space
    vecs[26] = mk(1,0,1,32'hFFFF_FFFC,32'hAA00_0404, 1,32'h404, 0,32'h000,N);
    vecs[27] = mk(0,0,1,32'h000,32'hAA00_00FC, 1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,32'hAA00_00FC);

    reset = 1'b1; PC_next = '0; redirect = 1'b0; stall = 1'b0;
    imem_valid = 1'b0; imem_rdata = '0;
    #1;
    check("rst_ifid_valid", -1, {31'b0, ifid_valid}, 32'd0);
    check("rst_ifid_instr", -1, ifid_instr, N);
    check("rst_ifid_pc",    -1, ifid_pc,    32'h0);
    check("rst_imem_addr",  -1, imem_addr,  32'h0);
    check("rst_pc_added",   -1, PC_added,   32'h4);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      redirect   = vecs[i].redirect;
      stall      = vecs[i].stall;
      imem_valid = vecs[i].valid;
      PC_next    = vecs[i].pcn;
      imem_rdata = vecs[i].rdata;
      #1;
      check("imem_req",  i, {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check("imem_addr", i, imem_addr, vecs[i].exp_addr);
      check("pc_added",  i, PC_added,  vecs[i].exp_addr + 32'd4);
      @(posedge clk);
      #1;
      check("ifid_valid", i, {31'b0, ifid_valid}, {31'b0, vecs[i].exp_v});
      check("ifid_instr", i, ifid_instr, vecs[i].exp_instr);
      if (vecs[i].exp_v) check("ifid_pc", i, ifid_pc, vecs[i].exp_pc);
    end

`ifdef FETCH_PERF_EN
    check("perf_fetched",  NV, perf_fetched,  32'd12);
    check("perf_squashed", NV, perf_squashed, 32'd5);
`endif

    // asynchronous reset asserted mid-cycle clears outputs immediately
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0; imem_valid = 1'b0; PC_next = 32'h004;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ifid_valid", NV, {31'b0, ifid_valid}, 32'd0);
    check("mid_rst_ifid_instr", NV, ifid_instr, N);
    check("mid_rst_imem_addr",  NV, imem_addr,  32'h0);
    check("mid_rst_pc_added",   NV, PC_added,   32'h4);
`ifdef FETCH_PERF_EN
    check("mid_rst_perf_fetched", NV, perf_fetched, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_imem_req",  NV, {31'b0, imem_req}, 32'd1);
    check("post_rst_imem_addr", NV, imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
